// File: rtl/msg_frame_sequencer.sv
// msg_frame_sequencer: plays NUM_FRAMES stored display frames for DWELL_TICKS ticks each, then pulses done.
// Optional MSG_SEQ_LOOP_EN lets loop=1 wrap back to frame 0 at the end instead of finishing.
module msg_frame_sequencer #(
  parameter int NUM_FRAMES = 3,
  parameter int DWELL_TICKS = 4,
  parameter int DIGITS = 4,
  parameter int CODE_W = 4,
  parameter logic [NUM_FRAMES*(DIGITS+DIGITS*CODE_W)-1:0] FRAME_ROM = 60'hC0060_C00BE_80A4C,
  localparam int FW = DIGITS + DIGITS*CODE_W,
  localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int DC_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     tick,
  input  logic                     abort,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  output logic [FI_W-1:0]          frame_idx,
  output logic [DIGITS*CODE_W-1:0] digits,
  output logic [DIGITS-1:0]        blank
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_n;
  logic [FI_W-1:0] r_frame, w_frame_n;
  logic [DC_W-1:0] r_cnt, w_cnt_n;
  logic r_busy, r_done, w_done_n;
  logic [DIGITS*CODE_W-1:0] r_digits, w_digits_n;
  logic [DIGITS-1:0] r_blank, w_blank_n;
  logic [FW-1:0] w_word;
  logic w_end;
  logic w_unused;
  assign w_unused = loop;
`ifdef MSG_SEQ_LOOP_EN
  assign w_end = !loop;
`else
  assign w_end = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_frame  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_digits <= '0;
      r_blank  <= '1;
    end else begin
      r_state  <= w_state_n;
      r_frame  <= w_frame_n;
      r_cnt    <= w_cnt_n;
      r_busy   <= (w_state_n == S_RUN);
      r_done   <= w_done_n;
      r_digits <= w_digits_n;
      r_blank  <= w_blank_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_frame_n = r_frame;
    w_cnt_n   = r_cnt;
    w_done_n  = 1'b0;
    if (r_state == S_IDLE) begin
      if (start && !abort) begin
        w_state_n = S_RUN;
        w_frame_n = '0;
        w_cnt_n   = '0;
      end
    end else if (abort) begin
      w_state_n = S_IDLE;
      w_frame_n = '0;
      w_cnt_n   = '0;
    end else if (tick) begin
      if (r_cnt != DC_W'(DWELL_TICKS-1)) w_cnt_n = r_cnt + 1'b1;
      else begin
        w_cnt_n = '0;
        if (r_frame != FI_W'(NUM_FRAMES-1)) w_frame_n = r_frame + 1'b1;
        else begin
          w_frame_n = '0;
          w_state_n = w_end ? S_IDLE : S_RUN;
          w_done_n  = w_end;
        end
      end
    end
  end
  // Display values follow the next state so they land on the same edge as the state change.
  always_comb begin
    w_word     = FRAME_ROM[int'(w_frame_n)*FW +: FW];
    w_digits_n = (w_state_n == S_RUN) ? w_word[DIGITS*CODE_W-1:0] : '0;
    w_blank_n  = (w_state_n == S_RUN) ? w_word[FW-1 -: DIGITS] : '1;
  end
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_idx = r_frame;
  assign digits    = r_digits;
  assign blank     = r_blank;
endmodule

// File: tb/tb_msg_frame_sequencer.sv
// tb_msg_frame_sequencer: directed checks of the frame sequencer, plus a 1-frame/1-tick instance.
module tb_msg_frame_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, tick = 1'b0, abort = 1'b0, loop = 1'b0;
  logic busy, done, d1_busy, d1_done, d1_fi;
  logic [1:0] frame_idx;
  logic [15:0] digits, d1_digits;
  logic [3:0] blank, d1_blank;
  int n_tests = 0, n_fail = 0, n_done = 0, d0;

  msg_frame_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .abort(abort), .loop(loop),
    .busy(busy), .done(done), .frame_idx(frame_idx), .digits(digits), .blank(blank)
  );
  msg_frame_sequencer #(.NUM_FRAMES(1), .DWELL_TICKS(1), .FRAME_ROM(20'hC0060)) d1 (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .abort(abort), .loop(loop),
    .busy(d1_busy), .done(d1_done), .frame_idx(d1_fi), .digits(d1_digits), .blank(d1_blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_pulse();
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_digits", 32'(digits), 0);
    chk("rst_frame", 32'(frame_idx), 0);
    // normal sequence
    pulse_start();
    chk("f0_busy", 32'(busy), 1);
    chk("f0_blank", 32'(blank), 32'h8);
    chk("f0_digits", 32'(digits), 32'h0A4C);
    chk("d1_busy", 32'(d1_busy), 1);
    chk("d1_digits", 32'(d1_digits), 32'h0060);
    chk("d1_blank", 32'(d1_blank), 32'hC);
    for (int i = 0; i < 12; i++) begin
      tick_pulse();
      if (i == 0) begin
        chk("d1_done", 32'(d1_done), 1);
        chk("d1_idle", 32'(d1_busy), 0);
      end
      if (i == 2) chk("f0_hold", 32'(digits), 32'h0A4C);
      if (i == 3) begin
        chk("f1_blank", 32'(blank), 32'hC);
        chk("f1_digits", 32'(digits), 32'h00BE);
        chk("f1_idx", 32'(frame_idx), 1);
      end
      if (i == 7) begin
        chk("f2_digits", 32'(digits), 32'h0060);
        chk("f2_idx", 32'(frame_idx), 2);
      end
      if (i < 11) begin
        chk("no_early_done", 32'(done), 0);
        repeat (3) @(negedge clk);
      end
    end
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_blank", 32'(blank), 32'hF);
    chk("end_digits", 32'(digits), 0);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 0);
    // abort together with a tick in frame 1
    pulse_start();
    do_tick(4);
    chk("ab_f1", 32'(frame_idx), 1);
    d0 = n_done;
    tick = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_blank", 32'(blank), 32'hF);
    chk("ab_frame", 32'(frame_idx), 0);
    chk("ab_digits", 32'(digits), 0);
    do_tick(12);
    chk("ab_no_done", 32'(n_done), 32'(d0));
    chk("ab_still_idle", 32'(busy), 0);
    // start and abort together stay idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_idle", 32'(busy), 0);
    chk("sa_blank", 32'(blank), 32'hF);
    // start held through the whole run
    d0 = n_done;
    start = 1'b1;
    @(negedge clk);
    chk("sh_busy", 32'(busy), 1);
    do_tick(5);
    chk("sh_no_restart", 32'(frame_idx), 1);
    do_tick(6);
    tick_pulse();
    chk("sh_done", 32'(done), 1);
    chk("sh_busy_end", 32'(busy), 0);
    @(negedge clk);
    chk("sh_restart", 32'(busy), 1);
    chk("sh_done_low", 32'(done), 0);
    chk("sh_digits", 32'(digits), 32'h0A4C);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("sh_one_done", 32'(n_done), 32'(d0 + 1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("sh_abort", 32'(busy), 0);
    // asynchronous reset at frame 2, dwell 2
    pulse_start();
    do_tick(10);
    chk("rs_frame2", 32'(frame_idx), 2);
    #2 reset = 1'b1;
    #1;
    chk("rs_busy", 32'(busy), 0);
    chk("rs_blank", 32'(blank), 32'hF);
    chk("rs_digits", 32'(digits), 0);
    chk("rs_frame", 32'(frame_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_done", 32'(done), 0);
    chk("rs_idle", 32'(busy), 0);
`ifdef MSG_SEQ_LOOP_EN
    loop = 1'b1;
    pulse_start();
    do_tick(11);
    tick_pulse();
    chk("lp_frame", 32'(frame_idx), 0);
    chk("lp_digits", 32'(digits), 32'h0A4C);
    chk("lp_busy", 32'(busy), 1);
    chk("lp_no_done", 32'(done), 0);
    loop = 1'b0;
    repeat (3) @(negedge clk);
    do_tick(11);
    tick_pulse();
    chk("lp_done", 32'(done), 1);
    chk("lp_end_busy", 32'(busy), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
